// File: rtl/beta_irq_ctl_if.sv
// Memory-mapped register bus between the data-bus decoder and beta_irq_ctl.
//
// Handshake: a transfer happens on every clock edge where bus_sel is high.
// bus_we selects write (bus_wdata consumed that edge) or read (bus_rdata is
// valid from the following cycle and holds until the next read). There is
// no ready/stall; the register bank always accepts.
//
// Signals:
//   bus_sel   - register bank selected this cycle
//   bus_we    - write strobe, qualified by bus_sel
//   bus_adr   - byte offset, bits [4:2] pick the register
//   bus_wdata - write data
//   bus_rdata - registered read data
interface beta_irq_ctl_if;
    logic        bus_sel;
    logic        bus_we;
    logic [4:0]  bus_adr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_sel, bus_we, bus_adr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_sel, bus_we, bus_adr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/beta_irq_ctl.sv
// Vectored interrupt controller for the 2-stage Beta core.
//
// Collects NSRC edge-triggered sources, arbitrates by fixed priority
// (source 0 highest), presents irq/xadr to the core, treats the core's
// fetch of the vector address as acknowledge and blocks further requests
// until software writes EOI.
//
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   src          - raw asynchronous sources, rising edge requests
//   bus          - register bank (slave side of beta_irq_ctl_if)
//   cpu_ma       - core next-fetch address, compared against {1, xadr}
//   irq          - interrupt request to the core
//   xadr         - vector address for the current winner
//   in_service   - an interrupt was acknowledged and awaits EOI
//   dbg_state    - controller state (0 idle, 1 request, 2 service)
//
// Register map (bus_adr[4:2]):
//   0 PENDING (R, W1C)  1 MASK (R/W)  2 STATUS (R)  3 EOI (W)  4 SWSET (W)
module beta_irq_ctl #(
    parameter int          NSRC        = 8,
    parameter logic [30:0] VEC_BASE    = 31'h00000100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NSRC-1:0]   src,
    beta_irq_ctl_if.slave     bus,
    input  logic [31:0]       cpu_ma,
    output logic              irq,
    output logic [30:0]       xadr,
    output logic              in_service,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_EOI     = 3'd3;
    localparam logic [2:0] REG_SWSET   = 3'd4;

    state_t          r_state;
    logic [NSRC-1:0] r_sync [SYNC_STAGES];
    logic [NSRC-1:0] r_hist;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [3:0]      r_winner;

    logic            w_rd;
    logic            w_wr;
    logic [2:0]      w_reg;
    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_eligible;
    logic [NSRC-1:0] w_win_onehot;
    logic [3:0]      w_win_idx;
    logic            w_win_live;
    logic            w_ack;
    logic            w_eoi;
    logic [31:0]     w_rd_val;
    logic            w_unused;

    assign w_rd     = bus.bus_sel & ~bus.bus_we;
    assign w_wr     = bus.bus_sel & bus.bus_we;
    assign w_reg    = bus.bus_adr[4:2];
    assign w_eoi    = w_wr && (w_reg == REG_EOI);
    assign w_unused = ^{bus.bus_adr[1:0], bus.bus_wdata};

    // Edge seen at the output of the last synchronizer stage.
    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_eligible = r_pending & r_mask;
    assign w_ack      = (r_state == ST_REQ) && (cpu_ma == {1'b1, xadr});

    always_comb begin
        w_win_idx    = 4'd0;
        w_win_onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_win_idx = 4'(i);
        end
        for (int i = 0; i < NSRC; i++) begin
            w_win_onehot[i] = (r_winner == 4'(i));
        end
    end

    assign w_win_live = |(w_eligible & w_win_onehot);

    // Sets are OR-ed after clears so a same-cycle edge/SWSET survives a
    // W1C or acknowledge of the same bit.
    assign w_set = w_edge | ((w_wr && (w_reg == REG_SWSET)) ? bus.bus_wdata[NSRC-1:0] : '0);
    assign w_clr = ((w_wr && (w_reg == REG_PENDING)) ? bus.bus_wdata[NSRC-1:0] : '0)
                 | (w_ack ? w_win_onehot : '0);

    always_comb begin
        w_rd_val = '0;
        case (w_reg)
            REG_PENDING: w_rd_val[NSRC-1:0] = r_pending;
            REG_MASK:    w_rd_val[NSRC-1:0] = r_mask;
            REG_STATUS:  w_rd_val = {in_service, irq, 26'd0, r_winner};
            default:     w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_hist <= '0;
        end else begin
            r_sync[0] <= src;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending     <= '0;
            r_mask        <= '0;
            bus.bus_rdata <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_wr && (w_reg == REG_MASK)) r_mask <= bus.bus_wdata[NSRC-1:0];
            if (w_rd) bus.bus_rdata <= w_rd_val;
        end
    end

    // Request FSM. Winner and xadr are frozen while in REQ: a higher
    // priority arrival waits until the current request is acked or dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_winner   <= 4'd0;
            irq        <= 1'b0;
            xadr       <= VEC_BASE;
            in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_eligible) begin
                        r_winner <= w_win_idx;
                        xadr     <= VEC_BASE + {25'd0, w_win_idx, 2'b00};
                        irq      <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        irq        <= 1'b0;
                        in_service <= 1'b1;
                        r_state    <= ST_SERVICE;
                    end else if (!w_win_live) begin
                        irq     <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi) begin
                        in_service <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    irq     <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_beta_irq_ctl.sv
module tb_beta_irq_ctl;
  localparam int NSRC = 8;
  localparam logic [30:0] VEC_BASE = 31'h00000100;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic [31:0] cpu_ma = '0;
  logic irq;
  logic [30:0] xadr;
  logic in_service;
  logic [1:0] dbg_state;

  beta_irq_ctl_if bus_if();

  beta_irq_ctl #(.NSRC(NSRC), .VEC_BASE(VEC_BASE), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .src(src), .bus(bus_if), .cpu_ma(cpu_ma),
    .irq(irq), .xadr(xadr), .in_service(in_service), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sources are remembered as a history of samples; a request is born when
  // the sample taken S edges ago is high and the one before it was low.
  logic [NSRC-1:0] m_hist [0:S];
  logic [NSRC-1:0] m_pend, m_mask;
  int m_state; // 0 waiting for work, 1 requesting, 2 being serviced
  logic m_irq, m_insvc;
  logic [30:0] m_xadr;
  int m_win;
  logic [31:0] m_rdata;

  function automatic int lowest(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  logic m_wr, m_rd, m_ack, m_eoi;
  logic [2:0] m_reg;
  logic [NSRC-1:0] m_set, m_clr;
  logic [31:0] m_rd_val;

  always_comb begin
    m_wr = bus_if.bus_sel & bus_if.bus_we;
    m_rd = bus_if.bus_sel & ~bus_if.bus_we;
    m_reg = bus_if.bus_adr[4:2];
    m_ack = (m_state == 1) && (cpu_ma == {1'b1, m_xadr});
    m_eoi = m_wr && (m_reg == 3'd3);
    m_set = (m_hist[S-1] & ~m_hist[S]) | ((m_wr && m_reg == 3'd4) ? bus_if.bus_wdata[NSRC-1:0] : '0);
    m_clr = (m_wr && m_reg == 3'd0) ? bus_if.bus_wdata[NSRC-1:0] : '0;
    if (m_ack) m_clr[m_win] = 1'b1;
    m_rd_val = 32'd0;
    if (m_reg == 3'd0) m_rd_val = 32'(m_pend);
    else if (m_reg == 3'd1) m_rd_val = 32'(m_mask);
    else if (m_reg == 3'd2) m_rd_val = {m_insvc, m_irq, 26'd0, 4'(m_win)};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= S; k++) m_hist[k] <= '0;
      m_pend <= '0; m_mask <= '0; m_state <= 0; m_irq <= 1'b0; m_insvc <= 1'b0;
      m_xadr <= VEC_BASE; m_win <= 0; m_rdata <= '0;
    end else begin
      m_hist[0] <= src;
      for (int k = 1; k <= S; k++) m_hist[k] <= m_hist[k-1];
      m_pend <= (m_pend & ~m_clr) | m_set;
      if (m_wr && m_reg == 3'd1) m_mask <= bus_if.bus_wdata[NSRC-1:0];
      if (m_rd) m_rdata <= m_rd_val;
      if (m_state == 0) begin
        if ((m_pend & m_mask) != 0) begin
          m_win <= lowest(m_pend & m_mask);
          m_xadr <= VEC_BASE + 31'(4 * lowest(m_pend & m_mask));
          m_irq <= 1'b1;
          m_state <= 1;
        end
      end else if (m_state == 1) begin
        if (m_ack) begin
          m_irq <= 1'b0; m_insvc <= 1'b1; m_state <= 2;
        end else if (!(m_pend[m_win] && m_mask[m_win])) begin
          m_irq <= 1'b0; m_state <= 0;
        end
      end else begin
        if (m_eoi) begin
          m_insvc <= 1'b0; m_state <= 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      chk("xadr", {1'b0, xadr}, {1'b0, m_xadr});
      chk("in_service", {31'd0, in_service}, {31'd0, m_insvc});
      chk("rdata", bus_if.bus_rdata, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic bus_wr(input logic [4:0] adr, input logic [31:0] data);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_adr = adr; bus_if.bus_wdata = data;
    tick();
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] adr, output logic [31:0] data);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_adr = adr;
    tick();
    bus_if.bus_sel = 1'b0;
    data = bus_if.bus_rdata;
  endtask

  task automatic wait_irq(input string name);
    for (int i = 0; i < 20; i++) begin
      if (irq) break;
      tick();
    end
    chk(name, {31'd0, irq}, 32'd1);
  endtask

  task automatic ack(input logic [31:0] adr);
    cpu_ma = adr;
    tick();
    cpu_ma = 32'd0;
  endtask

  localparam logic [4:0] A_PEND = 5'd0, A_MASK = 5'd4, A_STAT = 5'd8, A_EOI = 5'd12, A_SWSET = 5'd16;

  logic [31:0] rd;

  initial begin
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_adr = '0; bus_if.bus_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_xadr", {1'b0, xadr}, 32'h100);
    chk("rst_insvc", {31'd0, in_service}, 32'd0);
    chk("rst_rdata", bus_if.bus_rdata, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single source, latency and ack
    bus_wr(A_MASK, 32'h01);
    src[0] = 1'b1;
    repeat (3) tick();
    chk("t1_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("t1_irq", {31'd0, irq}, 32'd1);
    chk("t1_xadr", {1'b0, xadr}, 32'h100);
    ack(32'h80000100);
    chk("t1_ack_irq", {31'd0, irq}, 32'd0);
    chk("t1_ack_insvc", {31'd0, in_service}, 32'd1);
    bus_rd(A_PEND, rd);
    chk("t1_pend", rd, 32'd0);
    src[0] = 1'b0;
    bus_wr(A_EOI, 32'd0);

    // 2: simultaneous edges, priority, back-to-back service
    bus_wr(A_MASK, 32'hFF);
    src[5] = 1'b1; src[2] = 1'b1;
    wait_irq("t2_wait");
    chk("t2_xadr", {1'b0, xadr}, 32'h108);
    ack(32'h80000108);
    chk("t2_insvc", {31'd0, in_service}, 32'd1);
    bus_wr(A_EOI, 32'd0);
    chk("t2_gap_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("t2_irq2", {31'd0, irq}, 32'd1);
    chk("t2_xadr2", {1'b0, xadr}, 32'h114);
    ack(32'h80000114);
    bus_wr(A_EOI, 32'd0);
    src = '0;

    // 3: mask removal while requesting
    bus_wr(A_SWSET, 32'h08);
    wait_irq("t3_wait");
    chk("t3_xadr", {1'b0, xadr}, 32'h10C);
    bus_wr(A_MASK, 32'h00);
    tick();
    chk("t3_drop", {31'd0, irq}, 32'd0);
    bus_wr(A_MASK, 32'h08);
    tick();
    chk("t3_reirq", {31'd0, irq}, 32'd1);
    chk("t3_rexadr", {1'b0, xadr}, 32'h10C);
    ack(32'h8000010C);
    bus_wr(A_EOI, 32'd0);

    // 4: set beats clear
    bus_wr(A_SWSET, 32'h02);
    src[1] = 1'b1;
    tick(); tick();
    bus_wr(A_PEND, 32'h02);
    bus_wr(A_SWSET, 32'h80);
    bus_rd(A_PEND, rd);
    chk("t4_pend", rd, 32'h82);
    src[1] = 1'b0;
    bus_wr(A_PEND, 32'hFF);

    // 5: arrivals during service wait for EOI
    bus_wr(A_MASK, 32'hFF);
    bus_wr(A_SWSET, 32'h10);
    wait_irq("t5_wait");
    chk("t5_xadr", {1'b0, xadr}, 32'h110);
    ack(32'h80000110);
    src[0] = 1'b1;
    repeat (5) tick();
    chk("t5_hold", {31'd0, irq}, 32'd0);
    bus_rd(A_STAT, rd);
    chk("t5_status", rd, 32'h80000004);
    bus_wr(A_EOI, 32'd0);
    chk("t5_eoi_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("t5_irq", {31'd0, irq}, 32'd1);
    chk("t5_xadr0", {1'b0, xadr}, 32'h100);
    ack(32'h80000100);
    bus_wr(A_EOI, 32'd0);
    src = '0;

    // 6: asynchronous reset mid-request
    bus_wr(A_SWSET, 32'h04);
    wait_irq("t6_wait");
    #2 reset_n = 1'b0;
    #1;
    chk("t6_irq", {31'd0, irq}, 32'd0);
    chk("t6_insvc", {31'd0, in_service}, 32'd0);
    chk("t6_xadr", {1'b0, xadr}, 32'h100);
    @(negedge clk); #1;
    reset_n = 1'b1;
    bus_rd(A_PEND, rd);
    chk("t6_pend", rd, 32'd0);
    bus_rd(A_MASK, rd);
    chk("t6_mask", rd, 32'd0);
    bus_wr(A_MASK, 32'hFF);
    repeat (4) tick();
    chk("t6_noirq", {31'd0, irq}, 32'd0);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      int op;
      if ($urandom_range(0, 5) == 0) src = src ^ NSRC'($urandom);
      if (m_state == 1 && $urandom_range(0, 3) == 0) cpu_ma = {1'b1, m_xadr};
      else cpu_ma = $urandom & 32'h7FFFFFFF;
      op = $urandom_range(0, 11);
      bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
      bus_if.bus_wdata = $urandom;
      case (op)
        0, 1: begin bus_if.bus_sel = 1'b1; bus_if.bus_adr = 5'($urandom_range(0, 31)); end
        2: begin bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_adr = A_MASK; end
        3: begin bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_adr = A_PEND; end
        4: begin bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_adr = A_SWSET;
                 bus_if.bus_wdata = 32'(1 << $urandom_range(0, NSRC - 1)); end
        5, 6: begin bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_adr = A_EOI; end
        7: begin bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1;
                 bus_if.bus_adr = {3'($urandom_range(5, 7)), 2'($urandom_range(0, 3))}; end
        default: ;
      endcase
      tick();
    end
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0; cpu_ma = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
